// File: rtl/cache_pkg.sv
// Shared types and width helpers for the set-associative data cache.
package cache_pkg;

   localparam int unsigned WORD_W = 32;

   // Default geometry; the top level recomputes these from its own parameters.
   localparam int unsigned DEF_ADDR_W     = 18;
   localparam int unsigned DEF_WAYS       = 2;
   localparam int unsigned DEF_SETS       = 64;
   localparam int unsigned DEF_LINE_WORDS = 2;
   localparam int unsigned DEF_WB         = $clog2(DEF_LINE_WORDS);
   localparam int unsigned DEF_IB         = $clog2(DEF_SETS);
   localparam int unsigned DEF_TAG_W      = DEF_ADDR_W - 2 - DEF_WB - DEF_IB;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FILL  = 2'd1,
      ST_WRITE = 2'd2
   } state_t;

   // Index width that never collapses to zero bits for a single-entry range.
   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cache_way_store.sv
// One way of the cache: per-set valid bit, tag and line storage.
// Combinational read port; line fill and single-word update write ports.
module cache_way_store
   import cache_pkg::*;
#(
   parameter int unsigned SETS       = 64,
   parameter int unsigned LINE_WORDS = 2,
   parameter int unsigned TAG_W      = 9
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [$clog2(SETS)-1:0]             index_i,
   output logic                                valid_o,
   output logic [TAG_W-1:0]                    tag_o,
   output logic [WORD_W*LINE_WORDS-1:0]        line_o,
   input  logic                                line_we_i,
   input  logic [TAG_W-1:0]                    tag_i,
   input  logic [WORD_W*LINE_WORDS-1:0]        line_i,
   input  logic                                word_we_i,
   input  logic [idx_w(LINE_WORDS)-1:0]        word_sel_i,
   input  logic [WORD_W-1:0]                   word_i
);

   logic [SETS-1:0]                 valid_q;
   logic [TAG_W-1:0]                tag_q  [SETS];
   logic [WORD_W*LINE_WORDS-1:0]    data_q [SETS];

   // Valid bits: cleared by reset, set when a line is filled.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
      end else if (line_we_i) begin
         valid_q[index_i] <= 1'b1;
      end
   end

   // Tag and data arrays: a fill writes the whole line, a write hit patches one word.
   // NOTE: tag/data are deliberately not reset; a cleared valid bit makes their contents irrelevant.
   always_ff @(posedge clk) begin
      if (line_we_i) begin
         tag_q[index_i]  <= tag_i;
         data_q[index_i] <= line_i;
      end else if (word_we_i) begin
         data_q[index_i][word_sel_i*WORD_W +: WORD_W] <= word_i;
      end
   end

   assign valid_o = valid_q[index_i];
   assign tag_o   = tag_q[index_i];
   assign line_o  = data_q[index_i];

endmodule

// File: rtl/set_assoc_cache.sv
// Write-through, no-write-allocate, N-way set-associative data cache.
// Read hits return in the same cycle; misses fill a line from SRAM, writes go through to SRAM.
module set_assoc_cache
   import cache_pkg::*;
#(
   parameter int unsigned ADDR_W     = DEF_ADDR_W,
   parameter int unsigned WAYS       = DEF_WAYS,
   parameter int unsigned SETS       = DEF_SETS,
   parameter int unsigned LINE_WORDS = DEF_LINE_WORDS,
   parameter int unsigned CNT_W      = 32
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          rd_en,
   input  logic                          wr_en,
   input  logic [31:0]                   address,
   input  logic [31:0]                   wr_data,
   output logic [31:0]                   rd_data,
   output logic                          pause,
   output logic                          mem_rd_req,
   output logic                          mem_wr_req,
   output logic [ADDR_W-1:0]             mem_addr,
   output logic [31:0]                   mem_wr_data,
   input  logic [WORD_W*LINE_WORDS-1:0]  mem_rd_line,
   input  logic                          mem_ready,
   output logic [CNT_W-1:0]              hit_cnt,
   output logic [CNT_W-1:0]              miss_cnt
);

   localparam int unsigned WB     = $clog2(LINE_WORDS);
   localparam int unsigned IB     = $clog2(SETS);
   localparam int unsigned TAG_W  = ADDR_W - 2 - WB - IB;
   localparam int unsigned WBS    = idx_w(LINE_WORDS);
   localparam int unsigned WAYB   = idx_w(WAYS);
   localparam int unsigned LINE_W = WORD_W * LINE_WORDS;

   logic [ADDR_W-1:0] addr;
   logic [WBS-1:0]    word_idx;
   logic [IB-1:0]     set_idx;
   logic [TAG_W-1:0]  tag;
   logic [ADDR_W-1:0] line_addr;
   logic [ADDR_W-1:0] word_addr;
   logic              unused_addr_bits;

   assign addr             = address[ADDR_W-1:0];
   assign word_idx         = WBS'(addr[ADDR_W-1:2] & (LINE_WORDS - 1));
   assign set_idx          = IB'(addr >> (WB + 2));
   assign tag              = TAG_W'(addr >> (WB + IB + 2));
   assign line_addr        = addr & ~ADDR_W'(LINE_WORDS * 4 - 1);
   assign word_addr        = addr & ~ADDR_W'(3);
   assign unused_addr_bits = ^{address[31:ADDR_W], address[1:0]};

   logic [WAYS-1:0]   way_valid;
   logic [TAG_W-1:0]  way_tag  [WAYS];
   logic [LINE_W-1:0] way_line [WAYS];
   logic [WAYS-1:0]   tag_match;
   logic              any_match;
   logic [LINE_W-1:0] hit_line;
   logic [WBS-1:0]    hit_word_sel;
   logic [WAYB-1:0]   victim;
   logic [WAYB-1:0]   rr_q [SETS];

   state_t            state_q, state_d;
   logic              fill_we, word_we, hit_inc, miss_inc;
   logic [CNT_W-1:0]  hit_cnt_q, miss_cnt_q;

   // Way storage, one instance per way; writes are suppressed while reset is asserted.
   for (genvar w = 0; w < WAYS; w++) begin : g_way
      cache_way_store #(
         .SETS       (SETS),
         .LINE_WORDS (LINE_WORDS),
         .TAG_W      (TAG_W)
      ) u_way (
         .clk        (clk),
         .rst        (rst),
         .index_i    (set_idx),
         .valid_o    (way_valid[w]),
         .tag_o      (way_tag[w]),
         .line_o     (way_line[w]),
         .line_we_i  (fill_we && !rst && (victim == WAYB'(w))),
         .tag_i      (tag),
         .line_i     (mem_rd_line),
         .word_we_i  (word_we && !rst && tag_match[w]),
         .word_sel_i (word_idx),
         .word_i     (wr_data)
      );
   end

   // Tag compare across ways and selection of the matching line.
   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      tag_match = '0;
      hit_line  = '0;
      for (int w = 0; w < WAYS; w++) begin
         tag_match[w] = way_valid[w] && (way_tag[w] == tag);
         if (tag_match[w]) hit_line = hit_line | way_line[w];
      end
   end

   assign any_match    = |tag_match;
   assign hit_word_sel = word_idx;

   // Victim: lowest-index invalid way, otherwise the set's round-robin pointer.
   always_comb begin
      victim = rr_q[set_idx];
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!way_valid[w]) victim = WAYB'(w);
      end
   end

   // Control FSM: request decode in IDLE, hold SRAM request until mem_ready.
   always_comb begin
      state_d     = state_q;
      pause       = 1'b0;
      rd_data     = '0;
      mem_rd_req  = 1'b0;
      mem_wr_req  = 1'b0;
      mem_addr    = '0;
      mem_wr_data = '0;
      fill_we     = 1'b0;
      word_we     = 1'b0;
      hit_inc     = 1'b0;
      miss_inc    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (wr_en) begin
               pause   = 1'b1;
               word_we = any_match;
               state_d = ST_WRITE;
            end else if (rd_en) begin
               if (any_match) begin
                  rd_data = hit_line[hit_word_sel*WORD_W +: WORD_W];
                  hit_inc = 1'b1;
               end else begin
                  pause    = 1'b1;
                  miss_inc = 1'b1;
                  state_d  = ST_FILL;
               end
            end
         end
         ST_FILL: begin
            pause      = 1'b1;
            mem_rd_req = 1'b1;
            mem_addr   = line_addr;
            if (mem_ready) begin
               fill_we = 1'b1;
               state_d = ST_IDLE;
            end
         end
         ST_WRITE: begin
            mem_wr_req  = 1'b1;
            mem_addr    = word_addr;
            mem_wr_data = wr_data;
            pause       = !mem_ready;
            if (mem_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Per-set round-robin pointers, advanced on every completed fill.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
      end else if (fill_we) begin
         rr_q[set_idx] <= (rr_q[set_idx] == WAYB'(WAYS - 1)) ? '0 : rr_q[set_idx] + 1'b1;
      end
   end

   // Saturating hit/miss counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         if (hit_inc && (hit_cnt_q != '1))   hit_cnt_q  <= hit_cnt_q + 1'b1;
         if (miss_inc && (miss_cnt_q != '1)) miss_cnt_q <= miss_cnt_q + 1'b1;
      end
   end

   assign hit_cnt  = hit_cnt_q;
   assign miss_cnt = miss_cnt_q;

endmodule

// File: tb/tb_set_assoc_cache.sv
// Scoreboard bench for set_assoc_cache: driver pushes expectations from a
// behavioural cache model, a monitor and an SRAM responder pop and compare.
module tb_set_assoc_cache;

   logic        clk, rst, rd_en, wr_en, mem_ready;
   logic [31:0] address, wr_data, rd_data, mem_wr_data;
   logic        pause, mem_rd_req, mem_wr_req;
   logic [17:0] mem_addr;
   logic [63:0] mem_rd_line;
   logic [31:0] hit_cnt, miss_cnt;

   set_assoc_cache dut (
      .clk         (clk),
      .rst         (rst),
      .rd_en       (rd_en),
      .wr_en       (wr_en),
      .address     (address),
      .wr_data     (wr_data),
      .rd_data     (rd_data),
      .pause       (pause),
      .mem_rd_req  (mem_rd_req),
      .mem_wr_req  (mem_wr_req),
      .mem_addr    (mem_addr),
      .mem_wr_data (mem_wr_data),
      .mem_rd_line (mem_rd_line),
      .mem_ready   (mem_ready),
      .hit_cnt     (hit_cnt),
      .miss_cnt    (miss_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit          is_wr;
      bit          hit;
      logic [31:0] data;
      int          hits;
      int          misses;
   } exp_t;

   typedef struct {
      bit          is_wr;
      logic [17:0] addr;
      logic [31:0] data;
   } memop_t;

   exp_t   exp_q[$];
   memop_t memq[$];
   int     n_checks = 0;
   int     n_errors = 0;
   bit     auto_resp = 1'b1;

   // Reference model: SRAM contents plus per-set tag directory.
   logic [31:0] mem_words [int unsigned];
   bit          m_valid [64][2];
   int          m_tag   [64][2];
   int          m_rr    [64];
   int          m_hits, m_misses;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (mem_words.exists(a)) return mem_words[a];
      return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
   endfunction

   task automatic model_reset();
      for (int s = 0; s < 64; s++) begin
         m_rr[s] = 0;
         for (int w = 0; w < 2; w++) begin
            m_valid[s][w] = 1'b0;
            m_tag[s][w]   = 0;
         end
      end
      m_hits   = 0;
      m_misses = 0;
   endtask

   task automatic model_issue(input bit is_wr, input logic [31:0] addr, input logic [31:0] data);
      logic [31:0] a;
      int          set, tg, way, v;
      exp_t        e;
      memop_t      op;
      a   = addr & 32'h0003_FFFC;
      set = int'((a >> 3) & 32'd63);
      tg  = int'(a >> 9);
      way = -1;
      for (int w = 0; w < 2; w++)
         if (m_valid[set][w] && m_tag[set][w] == tg) way = w;
      e.is_wr = is_wr;
      e.hit   = (way >= 0);
      e.data  = '0;
      if (is_wr) begin
         op.is_wr = 1'b1; op.addr = a[17:0]; op.data = data;
         memq.push_back(op);
         mem_words[a] = data;
         e.hits = m_hits; e.misses = m_misses;
      end else if (way >= 0) begin
         e.data = mem_word(a); e.hits = m_hits; e.misses = m_misses;
         m_hits++;
      end else begin
         m_misses++;
         e.data = mem_word(a); e.hits = m_hits; e.misses = m_misses;
         op.is_wr = 1'b0; op.addr = a[17:0] & ~18'd7; op.data = '0;
         memq.push_back(op);
         v = -1;
         for (int w = 1; w >= 0; w--) if (!m_valid[set][w]) v = w;
         if (v < 0) begin
            v = m_rr[set];
         end
         m_rr[set]     = (m_rr[set] + 1) % 2;
         m_valid[set][v] = 1'b1;
         m_tag[set][v]   = tg;
         m_hits++;
      end
      exp_q.push_back(e);
   endtask

   task automatic do_req(input bit is_wr, input logic [31:0] addr, input logic [31:0] data);
      bit done;
      model_issue(is_wr, addr, data);
      @(posedge clk);
      #1;
      address = addr; wr_data = data; rd_en = !is_wr; wr_en = is_wr;
      done = 1'b0;
      for (int i = 0; i < 64 && !done; i++) begin
         @(negedge clk);
         if (!pause) done = 1'b1;
      end
      if (!done) check("req_timeout", 0, 1);
      @(posedge clk);
      #1;
      rd_en = 1'b0; wr_en = 1'b0;
   endtask

   // Monitor: a request completes in any cycle where it is presented with pause low.
   initial begin
      int   cyc;
      exp_t e;
      cyc = 0;
      forever begin
         @(negedge clk);
         if (!rst && (rd_en || wr_en)) begin
            assert (!(rd_en && wr_en)) else $error("rd_en and wr_en both asserted");
            cyc++;
            if (!pause) begin
               check("completion_expected", exp_q.size() != 0, 1);
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  check("rd_data", rd_data, e.data);
                  check("hit_cnt", hit_cnt, e.hits);
                  check("miss_cnt", miss_cnt, e.misses);
                  if (e.is_wr) begin
                     check("wr_release_on_ready", mem_ready, 1);
                  end else if (e.hit) begin
                     check("hit_latency", cyc, 1);
                  end else begin
                     check("miss_latency_ge3", cyc >= 3, 1);
                     check("miss_no_req_on_done", mem_rd_req, 0);
                  end
               end
               cyc = 0;
            end
         end else begin
            cyc = 0;
         end
      end
   end

   // SRAM responder: checks each request against the expected op, then acks after a random delay.
   initial begin
      memop_t op;
      int     lat;
      forever begin
         @(negedge clk);
         if (auto_resp && !rst && (mem_rd_req || mem_wr_req)) begin
            check("mem_req_expected", memq.size() != 0, 1);
            op.is_wr = mem_wr_req; op.addr = mem_addr; op.data = '0;
            if (memq.size() != 0) begin
               op = memq.pop_front();
               check("mem_req_kind", {mem_wr_req, mem_rd_req}, {op.is_wr, !op.is_wr});
               check("mem_addr", mem_addr, op.addr);
               if (op.is_wr) check("mem_wr_data", mem_wr_data, op.data);
            end
            lat = $urandom_range(1, 4);
            repeat (lat) @(posedge clk);
            #1;
            mem_ready   = 1'b1;
            mem_rd_line = {mem_word({14'd0, op.addr} + 32'd4), mem_word({14'd0, op.addr})};
            @(posedge clk);
            #1;
            mem_ready = 1'b0;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] ra;
      rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; address = '0; wr_data = '0;
      mem_ready = 1'b0; mem_rd_line = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("reset_pause", pause, 0);
      check("reset_mem_rd_req", mem_rd_req, 0);
      check("reset_mem_wr_req", mem_wr_req, 0);
      check("reset_hit_cnt", hit_cnt, 0);
      check("reset_miss_cnt", miss_cnt, 0);
      check("idle_rd_data", rd_data, 0);

      // Line fill, hit on the sibling word, write hit, write miss without allocation.
      mem_words[32'h40] = 32'hA;
      mem_words[32'h44] = 32'hB;
      do_req(1'b0, 32'h0000_0040, '0);
      do_req(1'b0, 32'h0000_0044, '0);
      do_req(1'b1, 32'h0000_0044, 32'h55);
      do_req(1'b0, 32'h0000_0044, '0);
      do_req(1'b1, 32'h0000_1000, 32'h77);
      do_req(1'b0, 32'h0000_1000, '0);

      // Reset in the middle of a fill; a late mem_ready must not install anything.
      auto_resp = 1'b0;
      @(posedge clk);
      #1 address = 32'h80; rd_en = 1'b1;
      @(negedge clk);
      check("abort_miss_pause", pause, 1);
      @(negedge clk);
      check("abort_fill_req", mem_rd_req, 1);
      check("abort_fill_addr", mem_addr, 18'h80);
      @(posedge clk);
      #1 rst = 1'b1; rd_en = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0; mem_ready = 1'b1; mem_rd_line = {32'hDEAD, 32'hBEEF};
      @(negedge clk);
      check("abort_pause", pause, 0);
      check("abort_no_req", mem_rd_req, 0);
      check("abort_hit_cnt", hit_cnt, 0);
      check("abort_miss_cnt", miss_cnt, 0);
      @(posedge clk);
      #1 mem_ready = 1'b0;
      model_reset();
      auto_resp = 1'b1;
      do_req(1'b0, 32'h0000_0080, '0);

      // Round-robin replacement in a fresh set 8.
      do_req(1'b0, 32'h0000_0240, '0);
      do_req(1'b0, 32'h0000_0440, '0);
      do_req(1'b0, 32'h0000_0640, '0);
      do_req(1'b0, 32'h0000_0440, '0);
      do_req(1'b0, 32'h0000_0240, '0);

      // Random mix over a small address pool so hits, misses and evictions all occur.
      for (int i = 0; i < 300; i++) begin
         ra = ($urandom_range(0, 3) << 9) | ($urandom_range(8, 9) << 3) |
              ($urandom_range(0, 1) << 2) | $urandom_range(0, 3);
         if ($urandom_range(0, 1) != 0) ra = ra | (32'h1 << $urandom_range(18, 31));
         if ($urandom_range(0, 9) < 3) do_req(1'b1, ra, $urandom);
         else                          do_req(1'b0, ra, '0);
      end

      repeat (10) @(posedge clk);
      check("exp_q_drained", exp_q.size(), 0);
      check("memq_drained", memq.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
